// File: rtl/seq_multiplier.sv
// Iterative shift-add multiply-accumulate: product = MULTIPLICAND*MULTIPLIER + ADDEND,
// one multiplier bit per clock. Optional early termination via SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             MULTIPLICAND,
  input  logic [WIDTH-1:0]             MULTIPLIER,
  input  logic [WIDTH-1:0]             ADDEND,
  output logic [2*WIDTH-1:0]           product,
  output logic                         ready,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bitt
);
  localparam int BW = $clog2(WIDTH+1);
  localparam int PW = 2*WIDTH;

  logic [PW-1:0]    mcand_r, acc, acc_nxt;
  logic [WIDTH-1:0] mult_r, mult_nxt;
  logic             finish;

  assign ready = (bitt == '0);

  always_comb begin
    acc_nxt  = mult_r[0] ? acc + mcand_r : acc;
    mult_nxt = mult_r >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    // Nothing left to add once the remaining multiplier bits are all zero.
    finish   = (bitt == BW'(1)) || (mult_nxt == '0);
`else
    finish   = (bitt == BW'(1));
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand_r <= '0;
      mult_r  <= '0;
      acc     <= '0;
      product <= '0;
      done    <= 1'b0;
      bitt    <= '0;
    end else begin
      done <= 1'b0;
      if (ready) begin
        if (start) begin
          mcand_r <= {{WIDTH{1'b0}}, MULTIPLICAND};
          mult_r  <= MULTIPLIER;
          acc     <= {{WIDTH{1'b0}}, ADDEND};
          bitt    <= BW'(WIDTH);
        end
      end else begin
        acc     <= acc_nxt;
        mcand_r <= mcand_r << 1;
        mult_r  <= mult_nxt;
        if (finish) begin
          product <= acc_nxt;
          done    <= 1'b1;
          bitt    <= '0;
        end else begin
          bitt    <= bitt - BW'(1);
        end
      end
    end
  end
endmodule
